alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator-side driver for the ALU operand protocol.
// Accepts one operation per request handshake and issues it to the ALU, either
// with both operands together or split into two phases with a gap. It then samples
// the ALU result after a fixed latency and returns it on a response handshake.
// All ALU drive outputs are registered, so they appear one cycle after the state
// that produces them.
// Optional feature: define ALU_SEQ_TIMEOUT_CHK_EN to flag long split gaps on RSP_TIMEOUT.
module alu_op_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned LAT     = 2,
  parameter int unsigned LAT_MUL = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_opa_i,
  input  logic [DW-1:0] req_opb_i,
  input  logic [CW-1:0] req_cmd_i,
  input  logic          req_mode_i,
  input  logic          req_cin_i,
  input  logic          req_split_i,
  input  logic [4:0]    req_gap_i,
  output logic [1:0]    inp_valid_o,
  output logic [DW-1:0] opa_o,
  output logic [DW-1:0] opb_o,
  output logic [CW-1:0] cmd_o,
  output logic          mode_o,
  output logic          cin_o,
  output logic          ce_o,
  input  logic [DW+1:0] res_i,
  input  logic          cout_i,
  input  logic          oflow_i,
  input  logic          g_i,
  input  logic          e_i,
  input  logic          l_i,
  input  logic          err_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW+1:0] rsp_res_o,
  output logic [5:0]    rsp_flags_o,
  output logic          rsp_timeout_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssueAb = 3'd1;
  localparam logic [2:0] StIssueA  = 3'd2;
  localparam logic [2:0] StGap     = 3'd3;
  localparam logic [2:0] StIssueB  = 3'd4;
  localparam logic [2:0] StWait    = 3'd5;
  localparam logic [2:0] StResp    = 3'd6;

  localparam int unsigned CntW = 8;
  localparam int unsigned RW   = DW + 2;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q;

  logic [DW-1:0]   cap_opa_q, cap_opb_q;
  logic [CW-1:0]   cap_cmd_q;
  logic            cap_mode_q, cap_cin_q;
  logic [4:0]      cap_gap_q;

  logic [1:0]      iv_q, iv_d;
  logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic            mode_q, mode_d, cin_q, cin_d, ce_q, ce_d;

  logic [DW+1:0]   rsp_res_q, res_smp;
  logic [5:0]      rsp_flags_q, flags_smp;

  logic            accept, is_mul, sample;
  logic [CntW-1:0] wait_load;

  // ready_q is only ever set while the FSM sits in IDLE
  assign accept    = ready_q & req_valid_i;
  assign is_mul    = cap_mode_q & ((cap_cmd_q == CW'(9)) | (cap_cmd_q == CW'(10)));
  assign wait_load = is_mul ? CntW'(LAT_MUL) : CntW'(LAT);
  assign sample    = (state_q == StWait) && (cnt_q == '0);

  // Next-state logic; cnt_q counts gap cycles in GAP and latency cycles in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = req_split_i ? StIssueA : StIssueAb;
      StIssueAb: begin
        state_d = StWait;
        cnt_d   = wait_load;
      end
      StIssueA: begin
        if (cap_gap_q == 5'd0) begin
          state_d = StIssueB;
        end else begin
          state_d = StGap;
          cnt_d   = CntW'(cap_gap_q) - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIssueB;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StIssueB: begin
        state_d = StWait;
        cnt_d   = wait_load;
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp:    if (rsp_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // ALU drive values for the next cycle; operands/command hold outside the issue states
  always_comb begin
    iv_d   = 2'b00;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cmd_d  = cmd_q;
    mode_d = mode_q;
    cin_d  = cin_q;
    ce_d   = 1'b0;
    unique case (state_q)
      StIssueAb: begin
        iv_d   = 2'b11;
        opa_d  = cap_opa_q;
        opb_d  = cap_opb_q;
        cmd_d  = cap_cmd_q;
        mode_d = cap_mode_q;
        cin_d  = cap_cin_q;
        ce_d   = 1'b1;
      end
      StIssueA: begin
        iv_d   = 2'b01;
        opa_d  = cap_opa_q;
        cmd_d  = cap_cmd_q;
        mode_d = cap_mode_q;
        cin_d  = cap_cin_q;
        ce_d   = 1'b1;
      end
      StGap:    ce_d = 1'b1;
      StIssueB: begin
        iv_d  = 2'b10;
        opb_d = cap_opb_q;
        cmd_d = cap_cmd_q;
        ce_d  = 1'b1;
      end
      // CE drops together with the sample so it is low once RSP_VALID rises
      StWait:   ce_d = (cnt_q != '0);
      default:  ;
    endcase
  end

  // Only a clean logic 1 on an ALU output is taken as 1; z and x read as 0
  always_comb begin
    res_smp = '0;
    for (int unsigned i = 0; i < RW; i++) res_smp[i] = (res_i[i] === 1'b1);
    flags_smp = {(err_i === 1'b1), (l_i === 1'b1), (e_i === 1'b1),
                 (g_i === 1'b1), (oflow_i === 1'b1), (cout_i === 1'b1)};
  end

  // FSM, counter, request capture and ALU drive registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      cap_opa_q  <= '0;
      cap_opb_q  <= '0;
      cap_cmd_q  <= '0;
      cap_mode_q <= 1'b0;
      cap_cin_q  <= 1'b0;
      cap_gap_q  <= '0;
      iv_q       <= 2'b00;
      opa_q      <= '0;
      opb_q      <= '0;
      cmd_q      <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StIdle);
      if (accept) begin
        cap_opa_q  <= req_opa_i;
        cap_opb_q  <= req_opb_i;
        cap_cmd_q  <= req_cmd_i;
        cap_mode_q <= req_mode_i;
        cap_cin_q  <= req_cin_i;
        cap_gap_q  <= req_gap_i;
      end
      iv_q   <= iv_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cmd_q  <= cmd_d;
      mode_q <= mode_d;
      cin_q  <= cin_d;
      ce_q   <= ce_d;
    end
  end

  // Response registers, loaded on the sampling edge and held through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else if (sample) begin
      rsp_res_q   <= res_smp;
      rsp_flags_q <= flags_smp;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_CHK_EN
  logic cap_split_q, rsp_timeout_q;

  // Long-gap flag, registered alongside the result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_split_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) cap_split_q <= req_split_i;
      if (sample) rsp_timeout_q <= cap_split_q & (cap_gap_q >= 5'd16);
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  assign req_ready_o = ready_q;
  assign inp_valid_o = iv_q;
  assign opa_o       = opa_q;
  assign opb_o       = opb_q;
  assign cmd_o       = cmd_q;
  assign mode_o      = mode_q;
  assign cin_o       = cin_q;
  assign ce_o        = ce_q;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_res_o   = rsp_res_q;
  assign rsp_flags_o = rsp_flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed and random operations. A stub ALU presents the
// expected result only in the cycle that must be sampled and garbage otherwise.
module tb_alu_op_sequencer;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 4;
  localparam int unsigned LAT     = 2;
  localparam int unsigned LAT_MUL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [DW-1:0] req_opa = '0, req_opb = '0;
  logic [CW-1:0] req_cmd = '0;
  logic          req_mode = 1'b0, req_cin = 1'b0, req_split = 1'b0;
  logic [4:0]    req_gap = '0;
  logic [1:0]    inp_valid;
  logic [DW-1:0] opa, opb;
  logic [CW-1:0] cmd;
  logic          mode, cin, ce;
  logic [DW+1:0] res = '0;
  logic          cout = 1'b0, oflow = 1'b0, g = 1'b0, e = 1'b0, l = 1'b0, err = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW+1:0] rsp_res;
  logic [5:0]    rsp_flags;
  logic          rsp_timeout;

  int total = 0;
  int bad   = 0;

  // Last operand/command values the bench expects to see held on the ALU bus
  logic [DW-1:0] last_opa = '0, last_opb = '0;
  logic [CW-1:0] last_cmd = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(DW), .CW(CW), .LAT(LAT), .LAT_MUL(LAT_MUL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_cmd_i(req_cmd),
    .req_mode_i(req_mode), .req_cin_i(req_cin), .req_split_i(req_split),
    .req_gap_i(req_gap),
    .inp_valid_o(inp_valid), .opa_o(opa), .opb_o(opb), .cmd_o(cmd),
    .mode_o(mode), .cin_o(cin), .ce_o(ce),
    .res_i(res), .cout_i(cout), .oflow_i(oflow), .g_i(g), .e_i(e), .l_i(l), .err_i(err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_flags_o(rsp_flags), .rsp_timeout_o(rsp_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub ALU: real value (with z on masked bits) when good, inverted garbage otherwise
  task automatic drive_alu(input logic good, input logic [9:0] rv, input logic [5:0] fv,
                           input logic [9:0] rz, input logic [5:0] fz);
    logic [9:0] r;
    logic [5:0] f;
    r = good ? rv : ~rv;
    f = good ? fv : ~fv;
    for (int i = 0; i < 10; i++) if (good && rz[i]) r[i] = 1'bz;
    for (int i = 0; i < 6; i++) if (good && fz[i]) f[i] = 1'bz;
    res = r;
    {err, l, e, g, oflow, cout} = f;
  endtask

  // One full operation: request, issue sequence, latency, response with bp stalled cycles
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic md, input logic ci, input logic sp, input logic [4:0] gp,
                        input int bp, input logic [9:0] rv, input logic [5:0] fv,
                        input logic [9:0] rz, input logic [5:0] fz);
    int n, lat, last;
    logic [1:0] iv_seq[$];
    logic [1:0] e_iv;
    logic [9:0] exp_res;
    logic [5:0] exp_flg;
    logic       exp_to;
    lat = (md && (c == 4'd9 || c == 4'd10)) ? LAT_MUL : LAT;
    if (sp) begin
      iv_seq.push_back(2'b01);
      for (int i = 0; i < int'(gp); i++) iv_seq.push_back(2'b00);
      iv_seq.push_back(2'b10);
    end else begin
      iv_seq.push_back(2'b11);
    end
    last    = iv_seq.size() - 1 + lat;
    exp_res = rv & ~rz;
    exp_flg = fv & ~fz;
`ifdef ALU_SEQ_TIMEOUT_CHK_EN
    exp_to = sp && (gp >= 5'd16);
`else
    exp_to = 1'b0;
`endif
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_opa = a; req_opb = b; req_cmd = c; req_mode = md; req_cin = ci;
    req_split = sp; req_gap = gp; req_valid = 1'b1;
    rsp_ready = (bp == 0);
    drive_alu(1'b0, rv, fv, rz, fz);
    @(negedge clk);
    req_valid = 1'b0;
    // cycle -1: accepted, nothing on the bus yet
    chk("pre_inp_valid", inp_valid, 0);
    chk("pre_ce", ce, 0);
    chk("pre_req_ready", req_ready, 0);
    chk("pre_opa_hold", opa, last_opa);
    @(negedge clk);
    for (int j = 0; j <= last; j++) begin
      e_iv = (j < iv_seq.size()) ? iv_seq[j] : 2'b00;
      chk("inp_valid", inp_valid, e_iv);
      chk("ce_busy", ce, 1);
      chk("rsp_valid_busy", rsp_valid, 0);
      if (e_iv[0]) begin
        last_opa = a;
        last_cmd = c;
        chk("mode", mode, md);
        chk("cin", cin, ci);
      end
      if (e_iv[1]) begin
        last_opb = b;
        last_cmd = c;
      end
      chk("opa", opa, last_opa);
      chk("opb", opb, last_opb);
      chk("cmd", cmd, last_cmd);
      drive_alu(j == last, rv, fv, rz, fz);
      @(negedge clk);
    end
    for (int k = 1; k <= bp + 1; k++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_res", rsp_res, exp_res);
      chk("rsp_flags", rsp_flags, exp_flg);
      chk("rsp_timeout", rsp_timeout, exp_to);
      chk("resp_ce", ce, 0);
      chk("resp_inp_valid", inp_valid, 0);
      chk("resp_req_ready", req_ready, 0);
      // A pending request during the stall must not be taken
      if (k == 1 && bp > 0) begin
        req_valid = 1'b1;
        req_opa   = ~a;
        req_split = 1'b0;
      end
      if (k == bp + 1) begin
        rsp_ready = 1'b1;
        req_valid = 1'b0;
      end
      drive_alu(1'b0, rv, fv, rz, fz);
      @(negedge clk);
    end
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_ce", ce, 0);
    chk("post_inp_valid", inp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] rc;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_inp_valid", inp_valid, 0);
    chk("rst_ops", {opa, opb, cmd, mode, cin, ce}, 0);
    chk("rst_rsp", {rsp_valid, rsp_res, rsp_flags, rsp_timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", req_ready, 1);

    // ADD FF+01, MUL class, split SUB
    run_op(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 0, 10'h100, 6'b000001, '0, '0);
    run_op(8'h03, 8'h05, 4'd1, 1'b1, 1'b0, 1'b1, 5'd5, 0, 10'h3FE, 6'b000010, '0, '0);
    run_op(8'h02, 8'h03, 4'd9, 1'b1, 1'b0, 1'b0, 5'd0, 0, 10'd12, 6'b000000, '0, '0);
    // CMD 10 multiply with some z on result/flags; CMD 9 in logic mode uses LAT
    run_op(8'h11, 8'h22, 4'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1, 10'h2A5, 6'b100001,
           10'h0A0, 6'b100000);
    run_op(8'h5A, 8'hA5, 4'd9, 1'b0, 1'b0, 1'b0, 5'd0, 0, 10'h155, 6'b010100, '0, '0);
    // Timeout boundary and zero gap
    run_op(8'h10, 8'h20, 4'd2, 1'b0, 1'b1, 1'b1, 5'd16, 0, 10'h0F0, 6'b001000, '0, '0);
    run_op(8'h30, 8'h40, 4'd3, 1'b0, 1'b0, 1'b1, 5'd15, 0, 10'h00F, 6'b000100, '0, '0);
    run_op(8'h77, 8'h88, 4'd4, 1'b1, 1'b0, 1'b1, 5'd0, 0, 10'h3C3, 6'b111111, '0, '0);
    // Backpressure for four cycles
    run_op(8'h0C, 8'h0D, 4'd0, 1'b1, 1'b1, 1'b0, 5'd0, 4, 10'h01A, 6'b000000, '0, '0);

    // Reset while waiting for the result
    req_opa = 8'hC3; req_opb = 8'h3C; req_cmd = 4'd0; req_mode = 1'b1;
    req_split = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_inp_valid", inp_valid, 0);
    chk("midrst_ce", ce, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_ops", {opa, opb, cmd}, 0);
    last_opa = '0; last_opb = '0; last_cmd = '0;
    drive_alu(1'b1, 10'h3FF, 6'h3F, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_rst_no_rsp", rsp_valid, 0);
      chk("after_rst_idle_bus", {inp_valid, ce}, 0);
    end
    run_op(8'h21, 8'h12, 4'd1, 1'b1, 1'b0, 1'b1, 5'd2, 0, 10'h00F, 6'b000010, '0, '0);

    // Random operations
    for (int t = 0; t < 20; t++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rc = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10;
      run_op(8'($urandom), 8'($urandom), rc, 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), 10'($urandom), 6'($urandom),
             10'($urandom & $urandom & $urandom), 6'($urandom & $urandom & $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
